// File: rtl/lifo_pop_reader.sv
// Purpose: read-side controller for a LIFO; pops N items (or drains to empty) and streams them out.
// Latency: pop strobe in cycle t, LIFO data captured at end of t+1, out_valid from cycle t+2.
// Backpressure: out_ready low holds the skid head; pops stop once outstanding + skid fill hits SKID_DEPTH.
// Optional feature: define LIFO_POP_READER_ABORT_EN to add an abort input that ends the pop phase early.
module lifo_pop_reader #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 8,
    parameter int SKID_DEPTH  = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic [COUNT_WIDTH-1:0] req_count,
    output logic                   req_ready,
    output logic                   lifo_pop,
    input  logic [DATA_WIDTH-1:0]  lifo_data,
    input  logic                   lifo_val,
    input  logic                   lifo_empty,
`ifdef LIFO_POP_READER_ABORT_EN
    input  logic                   abort,
`endif
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun,
    output logic [COUNT_WIDTH-1:0] popped_count
);

    // Skid pointer width; SKID_DEPTH is a power of two so pointers wrap naturally.
    localparam int AW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam logic [AW+1:0] SKID_LIMIT = (AW+2)'(SKID_DEPTH);
    localparam logic [AW:0]   SKID_FULL  = (AW+1)'(SKID_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Command context
    logic [COUNT_WIDTH-1:0] remaining;
    logic                   drain_mode;
    logic                   outstanding;
    logic                   abort_req;
    logic                   underrun_hit;

    // Skid FIFO
    logic [DATA_WIDTH-1:0]  skid_mem [SKID_DEPTH];
    logic [AW-1:0]          skid_wr_ptr;
    logic [AW-1:0]          skid_rd_ptr;
    logic [AW:0]            skid_level;
    logic                   skid_push;
    logic                   skid_pop;
    logic                   skid_vld;

    // Credit: a pop reserves a skid slot until its response lands
    logic [AW+1:0]          inflight;
    logic                   credit;

`ifdef LIFO_POP_READER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign skid_vld  = (skid_level != '0);
    // A response is only accepted when a pop is actually in flight.
    assign skid_push = lifo_val && outstanding;
    assign skid_pop  = skid_vld && out_ready;
    assign inflight  = {1'b0, skid_level} + {{(AW+1){1'b0}}, outstanding};
    assign credit    = (inflight < SKID_LIMIT);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: leave ISSUE on abort, count exhausted, or LIFO running dry
    always_comb begin
        state_nxt    = state;
        underrun_hit = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_req) begin
                    state_nxt = FLUSH;
                end else if (drain_mode) begin
                    if (lifo_empty && !lifo_pop) begin
                        state_nxt = FLUSH;
                    end
                end else if (remaining == '0) begin
                    state_nxt = FLUSH;
                end else if (lifo_empty) begin
                    state_nxt    = FLUSH;
                    underrun_hit = 1'b1;
                end
            end
            FLUSH: begin
                if (!outstanding && !skid_vld) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: handshake flags, pop strobe, and the skid head (zero when empty)
    always_comb begin
        req_ready = (state == IDLE);
        busy      = (state != IDLE);
        lifo_pop  = (state == ISSUE) && !reset && !abort_req && !lifo_empty &&
                    credit && (drain_mode || (remaining != '0));
        out_valid = skid_vld;
        out_data  = skid_vld ? skid_mem[skid_rd_ptr] : '0;
    end

    // Command bookkeeping: latch count on accept, track pops, flag underrun, pulse done
    always_ff @(posedge clock) begin
        if (reset) begin
            remaining    <= '0;
            drain_mode   <= 1'b0;
            popped_count <= '0;
            underrun     <= 1'b0;
            outstanding  <= 1'b0;
            done         <= 1'b0;
        end else begin
            outstanding <= lifo_pop;
            done        <= (state == FLUSH) && (state_nxt == IDLE);
            if ((state == IDLE) && req_valid) begin
                remaining    <= req_count;
                drain_mode   <= (req_count == '0);
                popped_count <= '0;
                underrun     <= 1'b0;
            end else if (lifo_pop) begin
                if (!drain_mode) begin
                    remaining <= remaining - 1'b1;
                end
                if (popped_count != '1) begin
                    popped_count <= popped_count + 1'b1;
                end
            end
            if (underrun_hit) begin
                underrun <= 1'b1;
            end
        end
    end

    // Skid pointers and fill level; reset discards anything buffered
    always_ff @(posedge clock) begin
        if (reset) begin
            skid_wr_ptr <= '0;
            skid_rd_ptr <= '0;
            skid_level  <= '0;
        end else begin
            if (skid_push) begin
                skid_wr_ptr <= skid_wr_ptr + 1'b1;
            end
            if (skid_pop) begin
                skid_rd_ptr <= skid_rd_ptr + 1'b1;
            end
            skid_level <= skid_level + {{AW{1'b0}}, skid_push} - {{AW{1'b0}}, skid_pop};
        end
    end

    // Skid storage, written with the captured LIFO word
    always_ff @(posedge clock) begin
        if (skid_push) begin
            skid_mem[skid_wr_ptr] <= lifo_data;
        end
    end

    // A LIFO response with no pop in flight would be silently lost.
    a_no_orphan_val: assert property (@(posedge clock) disable iff (reset) lifo_val |-> outstanding);

    // Credit accounting must keep the skid from ever overflowing.
    a_no_skid_overflow: assert property (@(posedge clock) disable iff (reset)
        !(skid_push && !skid_pop && (skid_level == SKID_FULL)));

endmodule

// File: tb/tb_lifo_pop_reader.sv
module tb_lifo_pop_reader;

    localparam int DW = 8;
    localparam int CW = 8;
    localparam int SD = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic [CW-1:0] req_count = '0;
    logic          req_ready;
    logic          lifo_pop;
    logic [DW-1:0] lifo_data = '0;
    logic          lifo_val = 1'b0;
    logic          lifo_empty = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          underrun;
    logic [CW-1:0] popped_count;
`ifdef LIFO_POP_READER_ABORT_EN
    logic          abort = 1'b0;
`endif

    always #5 clock = ~clock;

    lifo_pop_reader #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW), .SKID_DEPTH(SD)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_count(req_count),
        .req_ready(req_ready),
        .lifo_pop(lifo_pop),
        .lifo_data(lifo_data),
        .lifo_val(lifo_val),
        .lifo_empty(lifo_empty),
`ifdef LIFO_POP_READER_ABORT_EN
        .abort(abort),
`endif
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .underrun(underrun),
        .popped_count(popped_count)
    );

    // ---------------- LIFO model (registered data/val, empty from count) ----------------
    logic          lclr = 1'b0;
    logic          lpush = 1'b0;
    logic [DW-1:0] lpush_dat = '0;
    logic [DW-1:0] lmem[$];
    int            pops_total = 0;
    int            cyc = 0;
    int            pop_cyc[$];

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        lifo_val <= 1'b0;
        if (lclr) begin
            lmem.delete();
        end else if (lpush) begin
            lmem.push_back(lpush_dat);
        end else if (lifo_pop && lmem.size() > 0) begin
            lifo_data  <= lmem[lmem.size()-1];
            lifo_val   <= 1'b1;
            void'(lmem.pop_back());
            pops_total <= pops_total + 1;
            pop_cyc.push_back(cyc);
        end
        lifo_empty <= (lmem.size() == 0);
    end

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] shadow[$];     // what the LIFO should hold, bottom first
    logic [DW-1:0] exp_q[$];      // beats still owed to the stream
    logic [DW-1:0] got_q[$];      // beats seen on the stream
    bit            armed = 1'b0;
    int            exp_popped = 0;
    bit            exp_underrun = 1'b0;
    int            done_cnt = 0;
    int            beats_total = 0;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    initial begin
        bit            prev_hold;
        bit            prev_done;
        logic [DW-1:0] prev_dat;
        prev_hold = 0;
        prev_done = 0;
        prev_dat  = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                beats_total = pops_total;
                prev_hold   = 0;
                prev_done   = 0;
            end else begin
                chk(req_ready == !busy, "req_ready_vs_busy", req_ready, !busy);
                if (lifo_pop) chk(!lifo_empty, "pop_while_empty", lifo_empty, 0);
                chk(pops_total + int'(lifo_pop) - beats_total <= SD, "credit_inflight",
                    pops_total + int'(lifo_pop) - beats_total, SD);
                if (prev_hold) begin
                    chk(out_valid, "hold_valid", out_valid, 1);
                    chk(out_data == prev_dat, "hold_data", out_data, prev_dat);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk(0, "unexpected_beat", out_data, 0);
                    end else begin
                        chk(out_data == exp_q[0], "stream_data", out_data, exp_q[0]);
                        void'(exp_q.pop_front());
                    end
                    got_q.push_back(out_data);
                    beats_total++;
                end
                if (done) begin
                    chk(armed, "done_expected", done, armed);
                    chk(!prev_done, "done_one_cycle", prev_done, 0);
                    chk(int'(popped_count) == exp_popped, "done_popped_count", popped_count, exp_popped);
                    chk(underrun == exp_underrun, "done_underrun", underrun, exp_underrun);
                    chk(exp_q.size() == 0, "done_all_delivered", exp_q.size(), 0);
                    done_cnt++;
                end
                prev_hold = out_valid && !out_ready;
                prev_dat  = out_data;
                prev_done = done;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_item(input logic [DW-1:0] v);
        lpush     = 1'b1;
        lpush_dat = v;
        shadow.push_back(v);
        @(posedge clock); #1;
        lpush = 1'b0;
    endtask

    task automatic clear_lifo();
        lclr = 1'b1;
        shadow.delete();
        @(posedge clock); #1;
        lclr = 1'b0;
    endtask

    // Expected outcome from the LIFO contents: top-first items, min(count, size), drain = all.
    // force_k >= 0 caps the number of items (early stop without underrun).
    task automatic start_cmd(input int n, input int force_k);
        int sz;
        int k;
        sz = shadow.size();
        k  = (n == 0) ? sz : ((n < sz) ? n : sz);
        exp_underrun = (n != 0) && (sz < n);
        if (force_k >= 0) begin
            k = force_k;
            exp_underrun = 1'b0;
        end
        exp_popped = k;
        for (int i = 0; i < k; i++) begin
            exp_q.push_back(shadow[shadow.size()-1]);
            void'(shadow.pop_back());
        end
        got_q.delete();
        pop_cyc.delete();
        armed     = 1'b1;
        req_valid = 1'b1;
        req_count = CW'(n);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int pct);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            out_ready = ($urandom_range(0, 99) < pct);
            @(posedge clock); #1;
            if (done_cnt != d0) seen = 1;
        end
        if (!seen) chk(0, "done_timeout", 0, 1);
        armed = 1'b0;
        chk(lmem.size() == shadow.size(), "lifo_remaining", lmem.size(), shadow.size());
        if (lmem.size() > 0 && shadow.size() > 0)
            chk(lmem[lmem.size()-1] == shadow[shadow.size()-1], "lifo_top",
                lmem[lmem.size()-1], shadow[shadow.size()-1]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        int d0;
        repeat (3) @(posedge clock);
        #1;
        chk(busy == 0, "rst_busy", busy, 0);
        chk(req_ready == 1, "rst_req_ready", req_ready, 1);
        chk(out_valid == 0, "rst_out_valid", out_valid, 0);
        chk(out_data == 0, "rst_out_data", out_data, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(underrun == 0, "rst_underrun", underrun, 0);
        chk(popped_count == 0, "rst_popped_count", popped_count, 0);
        chk(lifo_pop == 0, "rst_lifo_pop", lifo_pop, 0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Count 2 from {10,20,30}
        clear_lifo();
        push_item(8'd10); push_item(8'd20); push_item(8'd30);
        out_ready = 1'b1;
        start_cmd(2, -1);
        wait_done(100);
        chk(got_q.size() == 2, "t1_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk(got_q[0] == 8'd30, "t1_beat0", got_q[0], 30);
            chk(got_q[1] == 8'd20, "t1_beat1", got_q[1], 20);
        end
        chk(pop_cyc.size() == 2, "t1_pops", pop_cyc.size(), 2);
        if (pop_cyc.size() == 2) chk(pop_cyc[1] - pop_cyc[0] == 1, "t1_pop_b2b", pop_cyc[1] - pop_cyc[0], 1);
        chk(popped_count == 8'd2, "t1_popped_count", popped_count, 2);
        chk(underrun == 1'b0, "t1_underrun", underrun, 0);
        chk(lmem.size() == 1, "t1_lifo_left", lmem.size(), 1);
        if (lmem.size() == 1) chk(lmem[0] == 8'd10, "t1_lifo_bottom", lmem[0], 10);

        // Drain 5
        clear_lifo();
        for (int i = 1; i <= 5; i++) push_item(DW'(11 * i));
        start_cmd(0, -1);
        wait_done(100);
        chk(popped_count == 8'd5, "t2_popped_count", popped_count, 5);
        chk(got_q.size() == 5, "t2_beats", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            chk(got_q[i] == DW'(11 * (5 - i)), "t2_order", got_q[i], 11 * (5 - i));

        // Count 4 with only 2 available
        clear_lifo();
        push_item(8'hA1); push_item(8'hB2);
        start_cmd(4, -1);
        wait_done(100);
        chk(underrun == 1'b1, "t3_underrun", underrun, 1);
        chk(popped_count == 8'd2, "t3_popped_count", popped_count, 2);

        // Drain 6 with a 10-cycle stall
        clear_lifo();
        for (int i = 0; i < 6; i++) push_item(DW'(8'h40 + i));
        out_ready = 1'b0;
        p0 = pops_total;
        start_cmd(0, -1);
        repeat (10) begin @(posedge clock); #1; end
        chk(pops_total - p0 == SD, "t4_stall_pops", pops_total - p0, SD);
        chk(lifo_pop == 1'b0, "t4_stall_no_pop", lifo_pop, 0);
        wait_done(100);
        chk(got_q.size() == 6, "t4_beats", got_q.size(), 6);

        // Empty LIFO: count then drain
        clear_lifo();
        start_cmd(3, -1);
        wait_done(100);
        chk(underrun == 1'b1, "t5_cnt_underrun", underrun, 1);
        chk(popped_count == 8'd0, "t5_cnt_popped", popped_count, 0);
        start_cmd(0, -1);
        wait_done(100);
        chk(underrun == 1'b0, "t5_drn_underrun", underrun, 0);

        // Reset two cycles after accept
        clear_lifo();
        for (int i = 0; i < 8; i++) push_item(DW'(8'h70 + i));
        out_ready = 1'b0;
        start_cmd(5, -1);
        @(posedge clock); #1;
        armed = 1'b0;
        reset = 1'b1;
        d0 = done_cnt;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_q.delete();
        chk(busy == 1'b0, "t6_busy", busy, 0);
        chk(out_valid == 1'b0, "t6_out_valid", out_valid, 0);
        chk(req_ready == 1'b1, "t6_req_ready", req_ready, 1);
        chk(done == 1'b0, "t6_done", done, 0);
        clear_lifo();
        repeat (4) begin @(posedge clock); #1; end
        chk(done_cnt == d0, "t6_no_done", done_cnt - d0, 0);

`ifdef LIFO_POP_READER_ABORT_EN
        // Abort after the third pop of a drain
        clear_lifo();
        for (int i = 0; i < 8; i++) push_item(DW'(3 * (i + 1)));
        out_ready = 1'b1;
        p0 = pops_total;
        start_cmd(0, 3);
        for (int c = 0; c < 200 && pops_total - p0 < 3; c++) begin @(posedge clock); #1; end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        wait_done(100);
        chk(pops_total - p0 == 3, "t7_abort_pops", pops_total - p0, 3);
        chk(lmem.size() == 5, "t7_abort_left", lmem.size(), 5);
        chk(got_q.size() == 3, "t7_abort_beats", got_q.size(), 3);
`endif

        // Randomized commands against the model
        clear_lifo();
        for (int it = 0; it < 30; it++) begin
            int nadd;
            int n;
            int pct;
            nadd = $urandom_range(0, 6);
            if (shadow.size() + nadd > 14) clear_lifo();
            for (int j = 0; j < nadd; j++) push_item(DW'($urandom_range(0, 255)));
            n   = $urandom_range(0, 8);
            pct = (it % 3 == 0) ? 100 : ((it % 3 == 1) ? 60 : 25);
            start_cmd(n, -1);
            wait_done(pct);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1);
    end

endmodule

// File: doc/lifo_pop_reader.md
Name: lifo_pop_reader

Overview:
- Read-side controller for the team's LIFO buffer. Accepts a pop command (N items, or drain-to-empty).
- Issues single-cycle pop strobes to the LIFO and captures its registered data_out/val response one cycle later.
- Re-presents the captured data as a ready/valid stream with backpressure, buffered in an internal skid FIFO.
- Sits between a lifo_buffer instance and any ready/valid consumer.

Parameters:
- DATA_WIDTH, 8, width of LIFO data words.
- COUNT_WIDTH, 8, width of req_count and popped_count.
- SKID_DEPTH, 2, internal skid FIFO entries; minimum 2, power of two.

Ports:
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- req_valid  input  1  command valid
- req_count  input  COUNT_WIDTH  items to pop; 0 = drain until LIFO empty
- req_ready  output  1  high only in IDLE
- lifo_pop  output  1  pop strobe to LIFO
- lifo_data  input  DATA_WIDTH  LIFO data_out
- lifo_val  input  1  LIFO val (data valid, 1 cycle after accepted pop)
- lifo_empty  input  1  LIFO empty flag
- out_data  output  DATA_WIDTH  stream data (skid head)
- out_valid  output  1  stream valid
- out_ready  input  1  stream ready
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse at command completion
- underrun  output  1  sticky per command: LIFO emptied before req_count items were popped
- popped_count  output  COUNT_WIDTH  items popped in current/last command

Behaviour:
- Reset values: state IDLE, lifo_pop 0, out_valid 0, out_data 0, done 0, underrun 0, popped_count 0, skid empty, outstanding 0.
- Command handshake: req_valid && req_ready accepted in IDLE.
  - On accept: remaining <= req_count; drain_mode <= (req_count == 0); popped_count <= 0; underrun <= 0; state -> ISSUE.
- Credit rule: outstanding (0 or 1) + skid occupancy < SKID_DEPTH is required to pop. This guarantees no lifo_val response is ever dropped.
- lifo_pop (combinational) = state==ISSUE && !lifo_empty && credit && (drain_mode || remaining != 0).
  - At most one pop per cycle; back-to-back pops are allowed while credit holds.
  - On pop: remaining decrements (count mode only); popped_count increments, saturating at all-ones; outstanding set for the next cycle.
- lifo_val high pushes lifo_data into the skid FIFO in that same cycle. A simultaneous push and pop on the skid FIFO is allowed.
- lifo_val with outstanding == 0: data is dropped. An assertion fires in simulation.
- Output stream:
  - out_valid = skid not empty; out_data = skid head.
  - Head pops when out_valid && out_ready.
  - out_data holds stable while out_valid && !out_ready.
- ISSUE -> FLUSH when:
  - count mode: remaining == 0, or lifo_empty && remaining != 0. The second case sets underrun.
  - drain mode: lifo_empty && !lifo_pop.
- FLUSH -> IDLE when outstanding == 0 && skid empty. done pulses for exactly one cycle on this transition.
- Ordering: stream order = pop order, i.e. LIFO order (last pushed first).
- Reset mid-command: returns to IDLE next cycle, skid contents discarded, no done pulse.
- req_valid while busy: ignored, req_ready = 0.
- LIFO empty at command accept: count mode goes ISSUE -> FLUSH -> IDLE with underrun=1, popped_count=0. Drain mode completes the same way with underrun=0.

Optional Feature:
- Macro LIFO_POP_READER_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort high in ISSUE: no further pops, state -> FLUSH. Outstanding and buffered items are still delivered, then done pulses.
  - abort in IDLE or FLUSH: ignored.
  - underrun is not set by an abort.
- Undefined: no abort port; commands always run to count or empty.

Test Plan:
- LIFO holds 10,20,30 (30 top); req_count=2, out_ready=1 -> lifo_pop on 2 consecutive cycles; stream 30 then 20; done pulse; popped_count=2; underrun=0; LIFO retains 10.
- LIFO holds 5 items; req_count=0 (drain), out_ready=1 -> 5 pops; stream in reverse push order; done after last beat; popped_count=5.
- LIFO holds 2 items; req_count=4 -> 2 pops; underrun=1; popped_count=2; done pulses.
- Drain 6 items with out_ready=0 for 10 cycles -> exactly SKID_DEPTH=2 pops, then lifo_pop stays 0; out_data stable. Release ready -> remaining 4 delivered in order, none lost.
- Reset asserted 2 cycles after accepting req_count=5 -> next cycle busy=0, out_valid=0, req_ready=1, no done pulse.
- With LIFO_POP_READER_ABORT_EN: req_count=0 on 8 items, abort after 3rd pop -> no 4th pop; 3 items streamed; done pulses; LIFO holds 5.
